// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// Carries register-file and HI/LO write-back; counts stalled cycles for performance monitoring.
module mem_wb_skid #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_whilo,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_whilo,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           main_q;
  entry_t           skid_q;
  entry_t           in_e;
  logic             main_valid;
  logic             skid_valid;
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] stall_q;

  assign in_e = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                  hi: mem_hi, lo: mem_lo, whilo: mem_whilo};

  // Ready comes only from registered state, so MEM never sees a combinational path from WB.
  assign mem_ready = !skid_valid && !rst;
  assign accept    = mem_valid && mem_ready;
  assign pop       = main_valid && wb_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      stall_q    <= '0;
    end else begin
      if (main_valid && !wb_ready && stall_q != CNT_MAX)
        stall_q <= stall_q + 1'b1;

      // Flush drops valid bits only; data fields keep their last values.
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || pop) begin
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= accept;
          if (accept)
            skid_q <= in_e;
        end else if (accept) begin
          main_q     <= in_e;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q     <= in_e;
        skid_valid <= 1'b1;
      end
    end
  end

  assign wb_valid  = main_valid;
  assign wb_wd     = main_q.wd;
  assign wb_wreg   = main_q.wreg && main_valid;
  assign wb_wdata  = main_q.wdata;
  assign wb_hi     = main_q.hi;
  assign wb_lo     = main_q.lo;
  assign wb_whilo  = main_q.whilo && main_valid;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Scoreboard bench for mem_wb_skid: a queue of accepted entries models the stage as a 2-deep FIFO;
// a negedge monitor compares whatever the DUT presents against the queue front.
module tb_mem_wb_skid;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b1;
  logic        mem_ready;
  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_hi = '0;
  logic [31:0] mem_lo = '0;
  logic        mem_whilo = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic [2:0]  stall_cnt;

  mem_wb_skid #(.ADDR_W(5), .DATA_W(32), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  entry_t      exp_q[$];
  logic        pend_accept = 1'b0;
  logic        primed = 1'b0;
  logic [31:0] model_stall = '0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply the effect of the edge that just passed to the model: flush/reset empty it, else push an accept.
  task automatic commitModel();
    if (rst || flush)
      exp_q.delete();
    else if (pend_accept)
      exp_q.push_back('{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                        hi: mem_hi, lo: mem_lo, whilo: mem_whilo});
    if (rst)
      primed = 1'b1;
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic rdy, input entry_t e);
    @(posedge clk);
    #1;
    commitModel();
    rst       = r;
    flush     = f;
    mem_valid = v;
    wb_ready  = rdy;
    mem_wd    = e.wd;
    mem_wreg  = e.wreg;
    mem_wdata = e.wdata;
    mem_hi    = e.hi;
    mem_lo    = e.lo;
    mem_whilo = e.whilo;
    pend_accept = v && !r && (exp_q.size() < 2);
  endtask

  function automatic entry_t mk(input int wd, input logic wreg, input logic [31:0] wdata,
                                input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    entry_t e;
    e.wd = 5'(wd); e.wreg = wreg; e.wdata = wdata; e.hi = hi; e.lo = lo; e.whilo = whilo;
    return e;
  endfunction

  // Monitor: mid-cycle, compare presented entry with the model, then retire it on a handshake.
  always @(negedge clk) begin
    logic   has_entry;
    entry_t front;
    has_entry = exp_q.size() != 0;
    if (primed) begin
      checkOutput("wb_valid", 32'(wb_valid), 32'(has_entry));
      checkOutput("mem_ready", 32'(mem_ready), 32'(!rst && exp_q.size() < 2));
      checkOutput("stall_cnt", 32'(stall_cnt), model_stall);
      if (has_entry) begin
        front = exp_q[0];
        checkOutput("wb_wd", 32'(wb_wd), 32'(front.wd));
        checkOutput("wb_wreg", 32'(wb_wreg), 32'(front.wreg));
        checkOutput("wb_wdata", wb_wdata, front.wdata);
        checkOutput("wb_hi", wb_hi, front.hi);
        checkOutput("wb_lo", wb_lo, front.lo);
        checkOutput("wb_whilo", 32'(wb_whilo), 32'(front.whilo));
        if (wb_ready && !rst)
          void'(exp_q.pop_front());
      end else begin
        checkOutput("bubble_wreg", 32'(wb_wreg), 32'd0);
        checkOutput("bubble_whilo", 32'(wb_whilo), 32'd0);
      end
    end
    if (rst)
      model_stall = 0;
    else if (has_entry && !wb_ready && model_stall < 7)
      model_stall = model_stall + 1;
  end

  entry_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0);

    // Reset held two cycles with mem_valid high
    applyStimulus(1, 0, 1, 0, mk(9, 1, 32'h99, 0, 0, 0));
    #2;
    checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_wd", 32'(wb_wd), 32'd0);
    checkOutput("rst_wb_wdata", wb_wdata, 32'd0);
    checkOutput("rst_wb_hi", wb_hi, 32'd0);
    checkOutput("rst_wb_lo", wb_lo, 32'd0);
    checkOutput("rst_stall", 32'(stall_cnt), 32'd0);
    applyStimulus(0, 0, 0, 1, idle);
    #2;
    checkOutput("post_rst_mem_ready", 32'(mem_ready), 32'd1);

    // Pass-through stream
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 1, 1, mk(i, 1, 32'(i * 'h11), 0, 0, 0));
      #2;
      checkOutput("pass_mem_ready", 32'(mem_ready), 32'd1);
    end
    applyStimulus(0, 0, 0, 1, idle);
    #2;
    checkOutput("pass_last_wd", 32'(wb_wd), 32'd4);

    // Back-pressure
    applyStimulus(1, 0, 0, 1, idle);
    applyStimulus(0, 0, 1, 0, mk(3, 1, 32'hA, 0, 0, 0));
    applyStimulus(0, 0, 1, 0, mk(4, 1, 32'hB, 0, 0, 0));
    applyStimulus(0, 0, 1, 0, mk(9, 1, 32'hC, 0, 0, 0));
    #2;
    checkOutput("bp_mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("bp_held_wd", 32'(wb_wd), 32'd3);
    applyStimulus(0, 0, 0, 1, idle);
    applyStimulus(0, 0, 0, 1, idle);
    #2;
    checkOutput("bp_second_wd", 32'(wb_wd), 32'd4);
    applyStimulus(0, 0, 0, 1, idle);
    #2;
    checkOutput("bp_drained", 32'(wb_valid), 32'd0);
    checkOutput("bp_stall_cnt", 32'(stall_cnt), 32'd2);

    // Flush with both entries full and a simultaneous input
    applyStimulus(0, 0, 1, 0, mk(5, 1, 32'h55, 0, 0, 1));
    applyStimulus(0, 0, 1, 0, mk(6, 1, 32'h66, 0, 0, 1));
    applyStimulus(0, 1, 1, 0, mk(7, 1, 32'h77, 0, 0, 1));
    applyStimulus(0, 0, 0, 1, idle);
    #2;
    checkOutput("fl_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("fl_wb_wreg", 32'(wb_wreg), 32'd0);
    checkOutput("fl_wb_whilo", 32'(wb_whilo), 32'd0);
    checkOutput("fl_mem_ready", 32'(mem_ready), 32'd1);
    applyStimulus(0, 0, 0, 1, idle);

    // HI/LO write-back
    applyStimulus(0, 0, 1, 0, mk(2, 0, 32'h1, 32'hDEAD, 32'hBEEF, 1));
    applyStimulus(0, 0, 0, 0, idle);
    #2;
    checkOutput("hl_hi", wb_hi, 32'hDEAD);
    checkOutput("hl_lo", wb_lo, 32'hBEEF);
    checkOutput("hl_whilo", 32'(wb_whilo), 32'd1);
    checkOutput("hl_wreg", 32'(wb_wreg), 32'd0);
    applyStimulus(0, 0, 0, 1, idle);
    applyStimulus(0, 0, 0, 1, idle);
    #2;
    checkOutput("hl_whilo_gone", 32'(wb_whilo), 32'd0);

    // Counter saturation at 7 with CNT_W=3
    applyStimulus(1, 0, 0, 0, idle);
    applyStimulus(0, 0, 1, 0, mk(1, 1, 32'h1, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 0, 0, idle);
    #2;
    checkOutput("sat_cnt", 32'(stall_cnt), 32'd7);
    applyStimulus(0, 0, 0, 0, idle);
    #2;
    checkOutput("sat_hold", 32'(stall_cnt), 32'd7);
    applyStimulus(1, 0, 0, 1, idle);
    applyStimulus(0, 0, 0, 1, idle);
    #2;
    checkOutput("sat_rst", 32'(stall_cnt), 32'd0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(31) == 0),
                    ($urandom_range(3) != 0), ($urandom_range(2) != 0),
                    mk(int'($urandom_range(31)), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom)));
    end

    // Drain
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 1, idle);
    #2;
    checkOutput("final_empty", 32'(wb_valid), 32'd0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised MEM/WB pipeline stage and successor to the fixed-width MEM/WB register.
- Carries the register-file write-back (address, enable, data) and the HI/LO write-back, widths set by parameters.
- Adds a valid/ready handshake with a 2-entry skid buffer, so write-back can back-pressure MEM without losing an instruction.
- Adds a synchronous flush and a saturating stall-cycle counter for performance monitoring.

Parameters:
ADDR_W, 5, register-file address width
DATA_W, 32, width of wdata, hi, lo
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous flush; discards all buffered entries
mem_valid  in  1  MEM stage presents a valid instruction
mem_ready  out  1  stage can accept an entry this cycle
mem_wd  in  ADDR_W  destination register address
mem_wreg  in  1  register-file write enable
mem_wdata  in  DATA_W  register-file write data
mem_hi  in  DATA_W  HI write data
mem_lo  in  DATA_W  LO write data
mem_whilo  in  1  HI/LO write enable
wb_valid  out  1  main entry is valid
wb_ready  in  1  write-back consumes the main entry this cycle
wb_wd  out  ADDR_W  main entry address
wb_wreg  out  1  main entry wreg AND wb_valid
wb_wdata  out  DATA_W  main entry write data
wb_hi  out  DATA_W  main entry HI
wb_lo  out  DATA_W  main entry LO
wb_whilo  out  1  main entry whilo AND wb_valid
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Storage: main entry (drives wb_*) and skid entry, each with a valid bit.
- Flags: accept = mem_valid & mem_ready; pop = wb_valid & wb_ready.
- mem_ready = !skid_valid & !rst. It is combinational from registered state and never depends on mem_valid or wb_ready in the same cycle.
- Reset (rst high at edge):
  - both valid bits 0; all wb_* fields 0; stall_cnt 0.
  - mem_ready reads 0 while rst is high and 1 on the first cycle after.
  - Reset overrides flush and every other input.
- Flush (rst low, flush high):
  - both valid bits cleared; accept in the same cycle is dropped.
  - Data fields hold their values; wb_wreg and wb_whilo read 0 because they are gated by valid.
  - stall_cnt is not affected.
- Normal update, priority order:
  1. main empty or pop, skid valid: skid moves to main; skid cleared. If accept is also true, the new entry goes to skid. This case is unreachable because mem_ready=0 while skid is valid.
  2. main empty or pop, skid empty, accept: the input loads main.
  3. main empty or pop, no accept: main valid cleared; fields hold.
  4. main valid and no pop, accept: the input loads skid (mem_ready=0 next cycle).
  5. otherwise: hold.
- Latency:
  - Entry accepted at edge N appears on wb_* after edge N, when main was empty or popping at N.
  - Throughput is 1 per cycle with wb_ready held high.
- Ordering: strict FIFO order; skid always drains into main before any newer entry.
- No duplication or loss: each accepted entry produces exactly one pop, unless a flush or reset discards it.
- Write enables: wb_wreg and wb_whilo are never 1 while wb_valid is 0. A bubble never writes the register file or HI/LO.
- stall_cnt:
  - Increments by 1 each cycle where wb_valid & !wb_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.

Test Plan:
- Reset: hold rst 2 cycles with mem_valid=1 -> all wb_* 0, wb_valid 0, mem_ready 0 during rst and 1 on the following cycle, stall_cnt 0.
- Pass-through: wb_ready=1; stream wd=1..4, wdata=0x11..0x44, wreg=1 -> each appears one cycle after acceptance, wb_wreg=1, in order, mem_ready stays 1.
- Back-pressure: wb_ready=0; send wd=3/wdata=0xA then wd=4/wdata=0xB.
  - Expect mem_ready=0 after the second accept and wb_wd=3 held; a third entry is not accepted.
  - Raise wb_ready -> wd=3 pops, then wd=4, then wb_valid=0; stall_cnt equals the stalled cycles.
- Flush: with both entries full (wd=5, wd=6), assert flush with mem_valid=1 wd=7.
  - Next cycle: wb_valid=0, wb_wreg=0, wb_whilo=0, mem_ready=1, wd=7 never appears.
- HI/LO: send whilo=1, hi=0xDEAD, lo=0xBEEF, wreg=0 -> wb_hi/wb_lo match, wb_whilo=1 only while wb_valid, wb_wreg=0.
- Counter saturation: CNT_W=3, wb_valid=1, wb_ready=0 for 10 cycles -> stall_cnt reaches 7 and holds at 7; rst returns it to 0.
